// File: rtl/mem_port_arbiter.sv
// Two-master (instruction/data) to one-slave arbiter for a split address/data handshake bus.
// Each accepted address records its owner in an in-order FIFO that routes the responses back.
module mem_port_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [3:0]  d_wstrb,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [3:0]  m_wstrb,
    output logic [2:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        busy,
    output logic        resp_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               gnt_i, gnt_d;

    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_err_q, resp_err_d;
    logic               owner_q [DEPTH];

    logic               full, empty;
    logic               push, pop;
    logic               head_owner;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);

    // Owner FSM: a grant that is not accepted in its first cycle is held
    // until the slave takes it or the owning master withdraws.
    always_comb begin
        state_d = state_q;
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (!full) begin
                        if (d_req) begin
                            gnt_d = 1'b1;
                            if (!m_addr_ok) state_d = LOCK_D;
                        end else if (i_req) begin
                            gnt_i = 1'b1;
                            if (!m_addr_ok) state_d = LOCK_I;
                        end
                    end
                end
                LOCK_I: begin
                    if (!i_req) begin
                        state_d = IDLE;
                    end else if (!full) begin
                        gnt_i = 1'b1;
                        if (m_addr_ok) state_d = IDLE;
                    end
                end
                LOCK_D: begin
                    if (!d_req) begin
                        state_d = IDLE;
                    end else if (!full) begin
                        gnt_d = 1'b1;
                        if (m_addr_ok) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slave request mux; instruction fetches are always full-word reads.
    always_comb begin
        m_req   = gnt_i | gnt_d;
        m_wr    = 1'b0;
        m_wstrb = 4'h0;
        m_size  = 3'd0;
        m_addr  = 32'h0;
        m_wdata = 32'h0;
        if (gnt_d) begin
            m_wr    = d_wr;
            m_wstrb = d_wstrb;
            m_size  = d_size;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (gnt_i) begin
            m_wstrb = 4'hF;
            m_size  = 3'd2;
            m_addr  = i_addr;
        end
    end

    assign i_addr_ok = m_addr_ok & m_req & gnt_i;
    assign d_addr_ok = m_addr_ok & m_req & gnt_d;

    assign push       = m_req & m_addr_ok;
    assign pop        = m_data_ok & ~empty;
    assign head_owner = owner_q[rptr_q];

    assign i_data_ok = pop & ~head_owner;
    assign d_data_ok = pop &  head_owner;
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

    assign busy     = ~empty;
    assign resp_err = resp_err_q;

    always_comb begin
        wptr_d     = wptr_q + PTR_W'(push);
        rptr_d     = rptr_q + PTR_W'(pop);
        cnt_d      = cnt_q;
        resp_err_d = resp_err_q | (m_data_ok & empty);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Owner IDs: 0 = instruction, 1 = data. Storage needs no reset; the count qualifies it.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_q[wptr_q] <= gnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_mem_port_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_wr;
    logic [3:0]  d_wstrb;
    logic [2:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req, m_wr;
    logic [3:0]  m_wstrb;
    logic [2:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        busy, resp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy), .resp_err(resp_err)
    );

    task automatic clear_inputs();
        i_req = 0; i_addr = 0;
        d_req = 0; d_wr = 0; d_wstrb = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk); m_data_ok = 1; m_rdata = $urandom;
        end
        @(negedge clk); m_data_ok = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req: got %b want 0", m_req); end
        total++; if ({i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 4'b0) begin bad++;
            $display("FAIL reset_handshakes: got %b want 0000", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}); end
        total++; if ({busy, resp_err} !== 2'b00) begin bad++; $display("FAIL reset_status: got %b want 00", {busy, resp_err}); end
        @(negedge clk); reset = 0; #1;
        total++; if ({m_req, busy} !== 2'b00) begin bad++; $display("FAIL after_reset_idle: got %b want 00", {m_req, busy}); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        i_req = 1; d_req = 1; i_addr = 32'h0000_1000; d_addr = 32'h0000_2004;
        d_wr = 1; d_wstrb = 4'h3; d_size = 3'd1; d_wdata = 32'hCAFE_0001; m_addr_ok = 1;
        #1;
        total++; if ({d_addr_ok, i_addr_ok} !== 2'b10) begin bad++; $display("FAIL prio_addr_ok: got d/i=%b want 10", {d_addr_ok, i_addr_ok}); end
        total++; if (m_addr !== 32'h0000_2004) begin bad++; $display("FAIL prio_m_addr: got %h want 00002004", m_addr); end
        total++; if ({m_wr, m_wstrb, m_size, m_wdata} !== {1'b1, 4'h3, 3'd1, 32'hCAFE_0001}) begin bad++;
            $display("FAIL prio_d_fields: got %b %h %0d %h", m_wr, m_wstrb, m_size, m_wdata); end
        @(negedge clk); d_req = 0; #1;
        total++; if ({i_addr_ok, d_addr_ok} !== 2'b10) begin bad++; $display("FAIL prio_inst_next: got i/d=%b want 10", {i_addr_ok, d_addr_ok}); end
        total++; if ({m_addr, m_wr, m_wstrb, m_size, m_wdata} !== {32'h0000_1000, 1'b0, 4'hF, 3'd2, 32'h0}) begin bad++;
            $display("FAIL prio_i_fields: got %h %b %h %0d %h", m_addr, m_wr, m_wstrb, m_size, m_wdata); end
        @(negedge clk); i_req = 0; m_addr_ok = 0; #1;
        total++; if ({busy, m_req} !== 2'b10) begin bad++; $display("FAIL prio_busy: got busy/m_req=%b want 10", {busy, m_req}); end
        @(negedge clk); m_data_ok = 1; m_rdata = 32'hAAAA_0001; #1;
        total++; if ({d_data_ok, i_data_ok, d_rdata} !== {2'b10, 32'hAAAA_0001}) begin bad++;
            $display("FAIL prio_resp1: got d/i=%b rdata=%h", {d_data_ok, i_data_ok}, d_rdata); end
        @(negedge clk); m_rdata = 32'hAAAA_0002; #1;
        total++; if ({i_data_ok, d_data_ok, i_rdata} !== {2'b10, 32'hAAAA_0002}) begin bad++;
            $display("FAIL prio_resp2: got i/d=%b rdata=%h", {i_data_ok, d_data_ok}, i_rdata); end
        @(negedge clk); m_data_ok = 0; clear_inputs(); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL prio_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_lock();
        @(negedge clk); i_req = 1; i_addr = 32'hBFC0_0000; m_addr_ok = 0; #1;
        total++; if ({m_req, i_addr_ok, m_addr} !== {2'b10, 32'hBFC0_0000}) begin bad++;
            $display("FAIL lock_c0: got m_req=%b i_addr_ok=%b m_addr=%h", m_req, i_addr_ok, m_addr); end
        @(negedge clk); #1;
        total++; if (m_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL lock_c1: got %h want bfc00000", m_addr); end
        @(negedge clk); d_req = 1; d_addr = 32'h8000_0040; #1;
        total++; if ({m_addr, d_addr_ok} !== {32'hBFC0_0000, 1'b0}) begin bad++;
            $display("FAIL lock_c2: got m_addr=%h d_addr_ok=%b", m_addr, d_addr_ok); end
        @(negedge clk); m_addr_ok = 1; #1;
        total++; if ({i_addr_ok, d_addr_ok, m_addr} !== {2'b10, 32'hBFC0_0000}) begin bad++;
            $display("FAIL lock_accept: got i/d=%b m_addr=%h", {i_addr_ok, d_addr_ok}, m_addr); end
        @(negedge clk); i_req = 0; #1;
        total++; if ({d_addr_ok, m_addr} !== {1'b1, 32'h8000_0040}) begin bad++;
            $display("FAIL lock_then_d: got d_addr_ok=%b m_addr=%h", d_addr_ok, m_addr); end
        @(negedge clk); clear_inputs(); drain(2);
        @(negedge clk); i_req = 1; m_addr_ok = 0;
        @(negedge clk); i_req = 0; #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL lock_drop_mreq: got %b want 0", m_req); end
        @(negedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL lock_drop_count: got busy=%b want 0", busy); end
        @(negedge clk); d_req = 1; m_addr_ok = 1; #1;
        total++; if ({d_addr_ok, i_addr_ok} !== 2'b10) begin bad++; $display("FAIL lock_drop_regrant: got d/i=%b want 10", {d_addr_ok, i_addr_ok}); end
        @(negedge clk); clear_inputs(); drain(1);
    endtask

    task automatic test_order();
        @(negedge clk); i_req = 1; i_addr = 32'h100; m_addr_ok = 1;
        @(negedge clk); i_req = 0; d_req = 1; d_addr = 32'h200;
        @(negedge clk); d_req = 0; i_req = 1; i_addr = 32'h104;
        @(negedge clk); i_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h11; #1;
        total++; if ({i_data_ok, d_data_ok, i_rdata} !== {2'b10, 32'h11}) begin bad++;
            $display("FAIL order_r1: got i/d=%b rdata=%h want 10 11", {i_data_ok, d_data_ok}, i_rdata); end
        @(negedge clk); m_rdata = 32'h22; #1;
        total++; if ({i_data_ok, d_data_ok, d_rdata} !== {2'b01, 32'h22}) begin bad++;
            $display("FAIL order_r2: got i/d=%b rdata=%h want 01 22", {i_data_ok, d_data_ok}, d_rdata); end
        @(negedge clk); m_rdata = 32'h33; #1;
        total++; if ({i_data_ok, d_data_ok, i_rdata} !== {2'b10, 32'h33}) begin bad++;
            $display("FAIL order_r3: got i/d=%b rdata=%h want 10 33", {i_data_ok, d_data_ok}, i_rdata); end
        @(negedge clk); m_data_ok = 0; #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL order_busy: got %b want 0", busy); end
    endtask

    task automatic test_full();
        repeat (DEPTH) begin
            @(negedge clk); i_req = 1; i_addr = $urandom; m_addr_ok = 1;
        end
        @(negedge clk); d_req = 1; #1;
        total++; if ({m_req, i_addr_ok, d_addr_ok, busy} !== 4'b0001) begin bad++;
            $display("FAIL full_block: got m_req/iok/dok/busy=%b want 0001", {m_req, i_addr_ok, d_addr_ok, busy}); end
        @(negedge clk); m_data_ok = 1; #1;
        total++; if ({m_req, i_data_ok} !== 2'b01) begin bad++; $display("FAIL full_pop_cycle: got m_req/i_data_ok=%b want 01", {m_req, i_data_ok}); end
        @(negedge clk); m_data_ok = 0; #1;
        total++; if ({m_req, d_addr_ok, i_addr_ok} !== 3'b110) begin bad++;
            $display("FAIL full_regrant: got m_req/dok/iok=%b want 110", {m_req, d_addr_ok, i_addr_ok}); end
        @(negedge clk); clear_inputs(); drain(DEPTH); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_drain: got busy=%b want 0", busy); end
    endtask

    task automatic test_push_pop();
        @(negedge clk); i_req = 1; m_addr_ok = 1; i_addr = 32'h10;
        @(negedge clk); i_addr = 32'h14;
        @(negedge clk); m_data_ok = 1; m_rdata = 32'h5A5A; i_addr = 32'h18; #1;
        total++; if ({i_addr_ok, i_data_ok} !== 2'b11) begin bad++; $display("FAIL pp_same_cycle: got iok/idok=%b want 11", {i_addr_ok, i_data_ok}); end
        @(negedge clk); m_data_ok = 0; #1;
        total++; if (i_addr_ok !== 1'b1) begin bad++; $display("FAIL pp_push3: got %b want 1", i_addr_ok); end
        @(negedge clk); #1;
        total++; if (i_addr_ok !== 1'b1) begin bad++; $display("FAIL pp_push4: got %b want 1", i_addr_ok); end
        @(negedge clk); #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL pp_full: got m_req=%b want 0", m_req); end
        @(negedge clk); clear_inputs(); drain(DEPTH); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pp_drain: got busy=%b want 0", busy); end
    endtask

    task automatic test_resp_err();
        @(negedge clk); clear_inputs(); m_data_ok = 1; #1;
        total++; if ({i_data_ok, d_data_ok, resp_err} !== 3'b000) begin bad++;
            $display("FAIL err_no_data_ok: got idok/ddok/err=%b want 000", {i_data_ok, d_data_ok, resp_err}); end
        @(negedge clk); m_data_ok = 0; #1;
        total++; if ({resp_err, busy} !== 2'b10) begin bad++; $display("FAIL err_set: got err/busy=%b want 10", {resp_err, busy}); end
        repeat (3) @(negedge clk);
        #1;
        total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", resp_err); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); i_req = 1; m_addr_ok = 1;
        @(negedge clk); i_req = 0; d_req = 1;
        @(negedge clk); clear_inputs(); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        @(negedge clk); reset = 1; #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rmid_m_req: got %b want 0", m_req); end
        @(negedge clk); reset = 0; #1;
        total++; if ({busy, resp_err} !== 2'b00) begin bad++; $display("FAIL rmid_cleared: got busy/err=%b want 00", {busy, resp_err}); end
        @(negedge clk); m_data_ok = 1; #1;
        total++; if ({i_data_ok, d_data_ok} !== 2'b00) begin bad++; $display("FAIL rmid_stale_resp: got %b want 00", {i_data_ok, d_data_ok}); end
        @(negedge clk); m_data_ok = 0; #1;
        total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL rmid_err: got %b want 1", resp_err); end
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0; #1;
        total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rmid_err_clear: got %b want 0", resp_err); end
    endtask

    // Model: a queue of owners (0 inst, 1 data) plus which master, if any, holds an unaccepted grant.
    task automatic test_random();
        int  q[$];
        int  lock_owner = -1;
        bit  err_m = 0;
        int  g;
        bit  pop_m, ok_i, ok_d;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            i_req     = ($urandom_range(0, 99) < 60);
            d_req     = ($urandom_range(0, 99) < 45);
            i_addr    = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_wr      = 1'($urandom); d_wstrb = 4'($urandom); d_size = 3'($urandom);
            m_addr_ok = ($urandom_range(0, 99) < 55);
            m_data_ok = (q.size() > 0) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 3);
            m_rdata   = $urandom;
            #1;
            g = -1;
            if (lock_owner == 0) g = (i_req && q.size() < DEPTH) ? 0 : -1;
            else if (lock_owner == 1) g = (d_req && q.size() < DEPTH) ? 1 : -1;
            else if (q.size() < DEPTH) g = d_req ? 1 : (i_req ? 0 : -1);
            pop_m = m_data_ok && (q.size() > 0);
            ok_i  = pop_m && (q[0] == 0);
            ok_d  = pop_m && (q[0] == 1);
            total++; if (m_req !== (g != -1)) begin bad++; $display("FAIL rnd_m_req cyc%0d: got %b want %b", cyc, m_req, g != -1); end
            total++; if ({i_addr_ok, d_addr_ok} !== {g == 0 && m_addr_ok, g == 1 && m_addr_ok}) begin bad++;
                $display("FAIL rnd_addr_ok cyc%0d: got i/d=%b%b grant=%0d", cyc, i_addr_ok, d_addr_ok, g); end
            if (g == 1) begin
                total++; if ({m_addr, m_wr, m_wstrb, m_size, m_wdata} !== {d_addr, d_wr, d_wstrb, d_size, d_wdata}) begin bad++;
                    $display("FAIL rnd_d_fields cyc%0d: got addr=%h want %h", cyc, m_addr, d_addr); end
            end else if (g == 0) begin
                total++; if ({m_addr, m_wr, m_wstrb, m_size, m_wdata} !== {i_addr, 1'b0, 4'hF, 3'd2, 32'h0}) begin bad++;
                    $display("FAIL rnd_i_fields cyc%0d: got addr=%h want %h", cyc, m_addr, i_addr); end
            end
            total++; if ({i_data_ok, d_data_ok} !== {ok_i, ok_d}) begin bad++;
                $display("FAIL rnd_data_ok cyc%0d: got i/d=%b%b want %b%b", cyc, i_data_ok, d_data_ok, ok_i, ok_d); end
            total++; if ({i_rdata, d_rdata} !== {m_rdata, m_rdata}) begin bad++;
                $display("FAIL rnd_rdata cyc%0d: got %h/%h want %h", cyc, i_rdata, d_rdata, m_rdata); end
            total++; if ({busy, resp_err} !== {q.size() != 0, err_m}) begin bad++;
                $display("FAIL rnd_status cyc%0d: got busy/err=%b%b want %b%b", cyc, busy, resp_err, q.size() != 0, err_m); end
            if (m_data_ok && q.size() == 0) err_m = 1;
            if (pop_m) void'(q.pop_front());
            if (g != -1 && m_addr_ok) q.push_back(g);
            if (g != -1) lock_owner = m_addr_ok ? -1 : g;
            else if ((lock_owner == 0 && !i_req) || (lock_owner == 1 && !d_req)) lock_owner = -1;
        end
        @(negedge clk); clear_inputs();
        drain(q.size()); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_final_busy: got %b want 0", busy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_priority();
        test_lock();
        test_order();
        test_full();
        test_push_pop();
        test_resp_err();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: maximum outstanding accepted requests (power of two, 2..16).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-003 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have the instruction master ports: i_req in 1; i_addr in 32; i_addr_ok out 1; i_data_ok out 1; i_rdata out 32. Instruction requests are word reads only.
REQ-005 SHALL have the data master ports: d_req in 1; d_wr in 1; d_wstrb in 4; d_size in 3; d_addr in 32; d_wdata in 32; d_addr_ok out 1; d_data_ok out 1; d_rdata out 32.
REQ-006 SHALL have the slave port: m_req out 1; m_wr out 1; m_wstrb out 4; m_size out 3; m_addr out 32; m_wdata out 32; m_addr_ok in 1; m_data_ok in 1; m_rdata in 32.
REQ-007 SHALL have status outputs: busy out 1 (outstanding count nonzero); resp_err out 1 (sticky: a response arrived with no request outstanding).

Function
REQ-008 SHALL use an owner FSM with states IDLE, LOCK_I and LOCK_D.
REQ-009 In IDLE with FIFO not full, SHALL grant the data master if d_req is high, otherwise the instruction master if i_req is high.
REQ-010 SHALL drive m_req, m_addr and the other m_* fields combinationally from the granted master; when it is a granted instruction request, m_wr=0, m_wstrb=4'hF, m_size=3'd2, m_wdata=0.
REQ-011 If the grant is issued while m_addr_ok is low, SHALL move to LOCK_I or LOCK_D next cycle and hold that grant until m_addr_ok, even if the other master requests; then return to IDLE.
REQ-012 In a LOCK state SHALL forward the locked master's req and fields unchanged; if that master drops req, SHALL return to IDLE without counting a transaction.
REQ-013 SHALL drive i_addr_ok/d_addr_ok = m_addr_ok AND m_req AND (granted master is that master); never both high.
REQ-014 Address handshake m_req&m_addr_ok SHALL push the owner ID (0 = inst, 1 = data) into an in-order FIFO of DEPTH entries.
REQ-015 When the FIFO is full, SHALL hold m_req=0 and both addr_ok=0, with no new grant, except in a LOCK state where it already holds an accepted-pending request it SHALL also hold m_req=0 until space frees. Count can never exceed DEPTH.
REQ-016 On m_data_ok with FIFO nonempty, SHALL pop the head ID and assert the matching i_data_ok or d_data_ok in the same cycle, with i_rdata = d_rdata = m_rdata passed through combinationally.
REQ-017 If a push and a pop occur in the same cycle, the count SHALL be unchanged and the pointers SHALL advance independently; a push into a full FIFO coincident with a pop is not permitted (full blocks it per REQ-015).
REQ-018 On m_data_ok with FIFO empty, SHALL assert no master data_ok, leave the FIFO unchanged, and set resp_err until reset.
REQ-019 FIFO pointers SHALL be log2(DEPTH) bits with natural wrap; the count SHALL be log2(DEPTH)+1 bits.
REQ-020 Zero-latency path: grant, address-accept and response routing SHALL add no cycles to the master handshakes.

Reset
REQ-021 While reset is high at a clock edge, the FSM SHALL go to IDLE, the FIFO pointers and count to 0, and resp_err to 0.
REQ-022 During and after reset, until a new request: m_req=0, all addr_ok/data_ok=0, busy=0. Reset mid-transaction SHALL discard outstanding IDs, and later slave responses SHALL set resp_err.

Verification
REQ-023 Simultaneous i_req and d_req in IDLE, m_addr_ok=1 -> d_addr_ok=1, i_addr_ok=0, m_addr=d_addr. Next cycle the inst request is granted.
REQ-024 i_req with i_addr=0xBFC00000, m_addr_ok low 3 cycles, d_req rising in cycle 2 -> m_addr stays 0xBFC00000 until accepted (LOCK_I). The data request is granted afterwards.
REQ-025 Accept I, D, I, then return 3 responses 0x11, 0x22, 0x33 -> i_data_ok with 0x11, d_data_ok with 0x22, i_data_ok with 0x33, in order; busy goes to 0 afterwards.
REQ-026 DEPTH=4: issue 4 accepted requests with no responses -> 5th request sees m_req=0. A response in the next cycle re-enables the grant.
REQ-027 Push and pop in the same cycle at count 2 -> count stays 2. Wrap test: 10 interleaved transactions route correctly.
REQ-028 m_data_ok with nothing outstanding -> no data_ok, resp_err=1 and held. Reset asserted mid-transaction -> busy=0, resp_err=0.
